// File: rtl/snn_ff_pkg.sv
// Shared definitions for the pre-neuron state sweep: state-word layout,
// FSM encoding and default trace dynamics.
package snn_ff_pkg;

    localparam int unsigned TRACE_LSB = 0;
    localparam int unsigned TRACE_W   = 16;
    localparam int unsigned COUNT_LSB = 16;
    localparam int unsigned COUNT_W   = 16;
    localparam int unsigned WORD_W    = COUNT_LSB + COUNT_W;

    localparam int unsigned          DECAY_SHIFT_DEF = 3;
    localparam logic [TRACE_W-1:0]   TRACE_INC_DEF   = 16'h0100;

    typedef struct packed {
        logic [COUNT_W-1:0] count;
        logic [TRACE_W-1:0] trace;
    } state_word_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_HRD   = 3'd3,
        ST_HWAIT = 3'd4
    } fsm_state_e;

endpackage

// File: rtl/pre_neuron_update_alu.sv
// Combinational trace decay/increment and spike-count update of one state word.
module pre_neuron_update_alu
    import snn_ff_pkg::*;
#(
    parameter int unsigned        DATA_WIDTH  = WORD_W,
    parameter int unsigned        DECAY_SHIFT = DECAY_SHIFT_DEF,
    parameter logic [TRACE_W-1:0] TRACE_INC   = TRACE_INC_DEF
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic                  spike_i,
    output logic [DATA_WIDTH-1:0] word_c
);

    localparam int unsigned EXT_W = TRACE_W + 1;

    state_word_t        cur;
    state_word_t        nxt;
    logic [TRACE_W-1:0] decay;
    logic [EXT_W-1:0]   trace_ext;
    logic [EXT_W-1:0]   count_ext;

    always_comb begin
        cur   = state_word_t'(word_i[WORD_W-1:0]);
        decay = cur.trace >> DECAY_SHIFT;
        // A non-zero trace always decays by at least one so it reaches zero.
        if ((decay == '0) && (cur.trace != '0)) begin
            decay = TRACE_W'(1);
        end

        trace_ext = EXT_W'(cur.trace) - EXT_W'(decay);
        if (spike_i) begin
            trace_ext = trace_ext + EXT_W'(TRACE_INC);
        end
        count_ext = EXT_W'(cur.count) + EXT_W'(spike_i);

        nxt.trace = trace_ext[TRACE_W] ? '1 : trace_ext[TRACE_W-1:0];
        nxt.count = count_ext[COUNT_W] ? '1 : count_ext[COUNT_W-1:0];

        word_c              = word_i;
        word_c[WORD_W-1:0]  = nxt;
    end

endmodule

// File: rtl/pre_neuron_updater.sv
// Sweeps the pre-neuron state SRAM once per TICK (read-modify-write per word)
// and serves single-word host read-backs between sweeps.
module pre_neuron_updater
    import snn_ff_pkg::*;
#(
    parameter int unsigned        ADDR_WIDTH  = 8,
    parameter int unsigned        DATA_WIDTH  = 32,
    parameter int unsigned        SRAM_DEPTH  = 256,
    parameter int unsigned        DECAY_SHIFT = DECAY_SHIFT_DEF,
    parameter logic [TRACE_W-1:0] TRACE_INC   = TRACE_INC_DEF
) (
    input  logic                  CK,
    input  logic                  RST_N,
    input  logic                  TICK,
    output logic [ADDR_WIDTH-1:0] SPK_ADDR,
    input  logic                  SPK_IN,
    output logic                  SRAM_CS,
    output logic                  SRAM_WE,
    output logic [ADDR_WIDTH-1:0] SRAM_A,
    output logic [DATA_WIDTH-1:0] SRAM_D,
    input  logic [DATA_WIDTH-1:0] SRAM_Q,
    input  logic                  HOST_REQ,
    input  logic [ADDR_WIDTH-1:0] HOST_ADDR,
    output logic                  HOST_ACK,
    output logic [DATA_WIDTH-1:0] HOST_RDATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVERRUN
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(SRAM_DEPTH - 1);

    fsm_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  spk_q, spk_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] spk_addr_q, spk_addr_d;
    logic                  ack_q, ack_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  ovr_q, ovr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] upd_word;

    pre_neuron_update_alu #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DECAY_SHIFT (DECAY_SHIFT),
        .TRACE_INC   (TRACE_INC)
    ) u_alu (
        .word_i  (SRAM_Q),
        .spike_i (spk_q),
        .word_c  (upd_word)
    );

    // State and registered outputs.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            spk_q      <= 1'b0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            spk_addr_q <= '0;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            spk_q      <= spk_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            spk_addr_q <= spk_addr_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
            rdata_q    <= rdata_d;
        end
    end

    // Next state; SRAM strobes are derived from the next state so they are
    // valid throughout the cycle the FSM spends in RD/WR/HRD.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        spk_d      = spk_q;
        rdata_d    = rdata_q;
        spk_addr_d = spk_addr_q;
        ovr_d      = ovr_q | (TICK & (state_q != ST_IDLE));

        unique case (state_q)
            ST_IDLE: begin
                if (TICK) begin
                    state_d = ST_RD;
                    idx_d   = '0;
                end else if (HOST_REQ) begin
                    state_d = ST_HRD;
                end
            end
            ST_RD: begin
                spk_d   = SPK_IN;
                state_d = ST_WR;
            end
            ST_WR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    state_d = ST_RD;
                end
            end
            ST_HRD: begin
                state_d = ST_HWAIT;
            end
            ST_HWAIT: begin
                rdata_d = SRAM_Q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_q == ST_WR) && (state_d == ST_IDLE);
        cs_d   = (state_d == ST_RD) || (state_d == ST_WR) || (state_d == ST_HRD);
        we_d   = (state_d == ST_WR);
        busy_d = (state_d == ST_RD) || (state_d == ST_WR);
        ack_d  = (state_d == ST_HWAIT);

        addr_d = '0;
        if ((state_d == ST_RD) || (state_d == ST_WR)) begin
            addr_d = idx_d;
        end else if (state_d == ST_HRD) begin
            addr_d = HOST_ADDR;
        end
        if (state_d == ST_RD) begin
            spk_addr_d = idx_d;
        end
    end

    // Write data and host read data follow SRAM_Q within the same cycle,
    // so these two outputs are decoded from the state rather than registered.
    assign SRAM_D     = (state_q == ST_WR)    ? upd_word : '0;
    assign HOST_RDATA = (state_q == ST_HWAIT) ? SRAM_Q   : rdata_q;

    assign SRAM_CS  = cs_q;
    assign SRAM_WE  = we_q;
    assign SRAM_A   = addr_q;
    assign SPK_ADDR = spk_addr_q;
    assign HOST_ACK = ack_q;
    assign DONE     = done_q;
    assign BUSY     = busy_q;
    assign OVERRUN  = ovr_q;

endmodule

// File: tb/tb_pre_neuron_updater.sv
// Testbench for pre_neuron_updater: behavioural SRAM, spike table and
// scoreboard queues for sweep writes and host read-backs.
`timescale 1ns/1ps
module tb_pre_neuron_updater;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic          CK       = 1'b0;
    logic          RST_N    = 1'b0;
    logic          TICK     = 1'b0;
    logic          HOST_REQ = 1'b0;
    logic [AW-1:0] HOST_ADDR = '0;
    logic [AW-1:0] SPK_ADDR;
    logic          SPK_IN;
    logic          SRAM_CS;
    logic          SRAM_WE;
    logic [AW-1:0] SRAM_A;
    logic [DW-1:0] SRAM_D;
    logic [DW-1:0] SRAM_Q;
    logic          HOST_ACK;
    logic [DW-1:0] HOST_RDATA;
    logic          BUSY;
    logic          DONE;
    logic          OVERRUN;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          spk_pat [DEPTH];
    wr_t           wr_q [$];
    logic [DW-1:0] host_q [$];
    int            errors = 0;
    int            checks = 0;

    pre_neuron_updater dut (
        .CK         (CK),
        .RST_N      (RST_N),
        .TICK       (TICK),
        .SPK_ADDR   (SPK_ADDR),
        .SPK_IN     (SPK_IN),
        .SRAM_CS    (SRAM_CS),
        .SRAM_WE    (SRAM_WE),
        .SRAM_A     (SRAM_A),
        .SRAM_D     (SRAM_D),
        .SRAM_Q     (SRAM_Q),
        .HOST_REQ   (HOST_REQ),
        .HOST_ADDR  (HOST_ADDR),
        .HOST_ACK   (HOST_ACK),
        .HOST_RDATA (HOST_RDATA),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .OVERRUN    (OVERRUN)
    );

    always #5 CK = ~CK;

    assign SPK_IN = spk_pat[SPK_ADDR];

    always @(posedge CK) begin
        if (SRAM_CS) begin
            if (SRAM_WE) mem[SRAM_A] <= SRAM_D;
            else         SRAM_Q <= mem[SRAM_A];
        end
    end

    // Reference update written with plain integer arithmetic.
    function automatic logic [31:0] model(input logic [31:0] w, input logic s);
        int unsigned tr, cn, dec, nt, nc;
        tr  = w[15:0];
        cn  = w[31:16];
        dec = tr / 8;
        if (dec == 0 && tr != 0) dec = 1;
        nt = tr - dec + (s ? 256 : 0);
        if (nt > 65535) nt = 65535;
        nc = cn + (s ? 1 : 0);
        if (nc > 65535) nc = 65535;
        return {nc[15:0], nt[15:0]};
    endfunction

    task automatic setup_pattern();
        logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            mem[i]     <= v;
            ref_mem[i] = v;
            spk_pat[i] = 1'($urandom_range(0, 1));
        end
        mem[0] <= 32'h0005_0100; ref_mem[0] = 32'h0005_0100; spk_pat[0] = 1'b1;
        mem[1] <= 32'h0000_0005; ref_mem[1] = 32'h0000_0005; spk_pat[1] = 1'b0;
        mem[2] <= 32'h0003_0000; ref_mem[2] = 32'h0003_0000; spk_pat[2] = 1'b0;
        mem[3] <= 32'hFFFF_0040; ref_mem[3] = 32'hFFFF_0040; spk_pat[3] = 1'b1;
        mem[5] <= 32'h0005_0100; ref_mem[5] = 32'h0005_0100; spk_pat[5] = 1'b0;
        @(negedge CK);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        @(negedge CK);
        @(negedge CK);
        checks++;
        if ({SRAM_CS, SRAM_WE, HOST_ACK, DONE, BUSY, OVERRUN} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {SRAM_CS, SRAM_WE, HOST_ACK, DONE, BUSY, OVERRUN});
        end
        checks++;
        if (SRAM_A !== '0 || SPK_ADDR !== '0) begin
            errors++;
            $display("FAIL reset_addr: got A=%0h SPK_ADDR=%0h expected 0", SRAM_A, SPK_ADDR);
        end
        checks++;
        if (SRAM_D !== '0 || HOST_RDATA !== '0) begin
            errors++;
            $display("FAIL reset_data: got D=%0h RDATA=%0h expected 0", SRAM_D, HOST_RDATA);
        end
        RST_N = 1'b1;
        repeat (3) @(negedge CK);
        checks++;
        if (SRAM_CS !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got CS=%b BUSY=%b expected 0 0", SRAM_CS, BUSY);
        end
    endtask

    task automatic test_sweep();
        wr_t w;
        int  done_at, done_n, busy_n, cs_n;
        setup_pattern();
        for (int i = 0; i < DEPTH; i++) begin
            w.addr = AW'(i);
            w.data = model(ref_mem[i], spk_pat[i]);
            wr_q.push_back(w);
            ref_mem[i] = w.data;
        end
        TICK = 1'b1;
        @(negedge CK);
        TICK = 1'b0;
        done_at = -1; done_n = 0; busy_n = 0; cs_n = 0;
        for (int k = 0; k < 520; k++) begin
            if (BUSY === 1'b1) busy_n++;
            if (SRAM_CS === 1'b1) cs_n++;
            if (DONE === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (k < 2 * DEPTH) begin
                checks++;
                if (SRAM_CS !== 1'b1 || SRAM_WE !== 1'(k % 2) || SRAM_A !== AW'(k / 2)) begin
                    errors++;
                    $display("FAIL sweep_seq[%0d]: got CS=%b WE=%b A=%0d expected 1 %0d %0d",
                             k, SRAM_CS, SRAM_WE, SRAM_A, k % 2, k / 2);
                end
                if (k % 2 == 0) begin
                    checks++;
                    if (SPK_ADDR !== AW'(k / 2)) begin
                        errors++;
                        $display("FAIL sweep_spk_addr[%0d]: got %0d expected %0d", k, SPK_ADDR, k / 2);
                    end
                end else if (wr_q.size() > 0) begin
                    w = wr_q.pop_front();
                    checks++;
                    if (SRAM_D !== w.data) begin
                        errors++;
                        $display("FAIL sweep_wdata[%0d]: got %08h expected %08h", w.addr, SRAM_D, w.data);
                    end
                end
            end
            @(negedge CK);
        end
        checks++;
        if (busy_n != 2 * DEPTH || cs_n != 2 * DEPTH) begin
            errors++;
            $display("FAIL sweep_len: got busy=%0d cs=%0d expected 512 512", busy_n, cs_n);
        end
        checks++;
        if (done_n != 1 || done_at != 2 * DEPTH) begin
            errors++;
            $display("FAIL sweep_done: got %0d pulses at %0d expected 1 at 512", done_n, done_at);
        end
        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL sweep_pending: got %0d unwritten expected 0", wr_q.size());
        end
        checks++;
        if (mem[0] !== 32'h0006_01E0) begin
            errors++;
            $display("FAIL word_spike: got %08h expected 000601e0", mem[0]);
        end
        checks++;
        if (mem[5] !== 32'h0005_00E0) begin
            errors++;
            $display("FAIL word_nospike: got %08h expected 000500e0", mem[5]);
        end
        checks++;
        if (mem[1] !== 32'h0000_0004) begin
            errors++;
            $display("FAIL trace_min_decay: got %08h expected 00000004", mem[1]);
        end
        checks++;
        if (mem[2] !== 32'h0003_0000) begin
            errors++;
            $display("FAIL trace_zero: got %08h expected 00030000", mem[2]);
        end
        checks++;
        if (mem[3] !== 32'hFFFF_0138) begin
            errors++;
            $display("FAIL count_sat: got %08h expected ffff0138", mem[3]);
        end
    endtask

    task automatic test_host_read();
        logic [AW-1:0] addrs [3];
        logic [DW-1:0] e;
        int            need, got, wait_n;
        addrs[0] = 8'd0; addrs[1] = 8'd5; addrs[2] = 8'd200;
        for (int n = 0; n < 3; n++) begin
            need = (n == 2) ? 2 : 1;
            got = 0; wait_n = 0;
            for (int r = 0; r < need; r++) host_q.push_back(ref_mem[addrs[n]]);
            HOST_REQ  = 1'b1;
            HOST_ADDR = addrs[n];
            while (got < need && wait_n < 20) begin
                @(negedge CK);
                wait_n++;
                if (HOST_ACK === 1'b1 && host_q.size() > 0) begin
                    e = host_q.pop_front();
                    checks++;
                    if (HOST_RDATA !== e) begin
                        errors++;
                        $display("FAIL host_rdata[%0d]: got %08h expected %08h", addrs[n], HOST_RDATA, e);
                    end
                    got++;
                    if (got == need) HOST_REQ = 1'b0;
                end
            end
            checks++;
            if (got != need) begin
                errors++;
                HOST_REQ = 1'b0;
                $display("FAIL host_ack_count[%0d]: got %0d acks expected %0d", addrs[n], got, need);
            end
            @(negedge CK);
            checks++;
            if (HOST_ACK !== 1'b0 || HOST_RDATA !== ref_mem[addrs[n]]) begin
                errors++;
                $display("FAIL host_hold[%0d]: got ack=%b data=%08h expected 0 %08h",
                         addrs[n], HOST_ACK, HOST_RDATA, ref_mem[addrs[n]]);
            end
            host_q.delete();
            @(negedge CK);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        int            done_at, ack_at, bad;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = model(ref_mem[i], spk_pat[i]);
        host_q.push_back(ref_mem[7]);
        TICK = 1'b1; HOST_REQ = 1'b1; HOST_ADDR = 8'd7;
        @(negedge CK);
        TICK = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || SRAM_WE !== 1'b0 || SRAM_A !== 8'd0) begin
            errors++;
            $display("FAIL b2b_priority: got BUSY=%b WE=%b A=%0d expected 1 0 0", BUSY, SRAM_WE, SRAM_A);
        end
        done_at = -1; ack_at = -1;
        for (int k = 0; k < 600 && ack_at < 0; k++) begin
            if (DONE === 1'b1) done_at = k;
            if (HOST_ACK === 1'b1) begin
                ack_at = k;
                e = host_q.pop_front();
                HOST_REQ = 1'b0;
                checks++;
                if (HOST_RDATA !== e) begin
                    errors++;
                    $display("FAIL b2b_rdata: got %08h expected %08h", HOST_RDATA, e);
                end
            end
            @(negedge CK);
        end
        HOST_REQ = 1'b0;
        checks++;
        if (done_at < 0 || ack_at < 0 || ack_at <= done_at || ack_at - done_at > 2) begin
            errors++;
            $display("FAIL b2b_ack_latency: got done=%0d ack=%0d expected ack 1..2 after done", done_at, ack_at);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_image: got %0d wrong words expected 0", bad);
        end
        host_q.delete();
        @(negedge CK);
    endtask

    task automatic test_overrun();
        int done_at, bad;
        checks++;
        if (OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL overrun_initial: got %b expected 0", OVERRUN);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = model(ref_mem[i], spk_pat[i]);
        TICK = 1'b1;
        @(negedge CK);
        TICK = 1'b0;
        done_at = -1;
        for (int k = 0; k < 520; k++) begin
            if (DONE === 1'b1 && done_at < 0) done_at = k;
            if (k == 21) begin
                checks++;
                if (OVERRUN !== 1'b1 || SRAM_A !== 8'd10 || SRAM_WE !== 1'b1) begin
                    errors++;
                    $display("FAIL overrun_set: got OVR=%b A=%0d WE=%b expected 1 10 1",
                             OVERRUN, SRAM_A, SRAM_WE);
                end
            end
            TICK = (k == 20);
            @(negedge CK);
        end
        TICK = 1'b0;
        checks++;
        if (done_at != 2 * DEPTH || OVERRUN !== 1'b1) begin
            errors++;
            $display("FAIL overrun_no_restart: got done=%0d OVR=%b expected 512 1", done_at, OVERRUN);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL overrun_image: got %0d wrong words expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int bad, cs_seen;
        for (int i = 0; i < 50; i++) ref_mem[i] = model(ref_mem[i], spk_pat[i]);
        TICK = 1'b1;
        @(negedge CK);
        TICK = 1'b0;
        repeat (100) @(negedge CK);
        RST_N = 1'b0;
        #1;
        checks++;
        if (SRAM_CS !== 1'b0 || BUSY !== 1'b0 || OVERRUN !== 1'b0 || SRAM_WE !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: got CS=%b WE=%b BUSY=%b OVR=%b expected 0 0 0 0",
                     SRAM_CS, SRAM_WE, BUSY, OVERRUN);
        end
        @(negedge CK);
        RST_N = 1'b1;
        cs_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CK);
            if (SRAM_CS !== 1'b0) cs_seen++;
        end
        checks++;
        if (cs_seen != 0) begin
            errors++;
            $display("FAIL abort_no_replay: got %0d CS cycles expected 0", cs_seen);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_image: got %0d wrong words expected 0", bad);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sweep();
        test_host_read();
        test_back_to_back();
        test_overrun();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
